// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU constants: unit IDs, result-entry width, ALU_FUN codes.
//               Entry width grows by one bit when ALU_COLLECT_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int UNIT_W    = 2;
  localparam int NUM_UNITS = 4;

  localparam logic [UNIT_W-1:0] UNIT_ARITH = 2'd0;
  localparam logic [UNIT_W-1:0] UNIT_LOGIC = 2'd1;
  localparam logic [UNIT_W-1:0] UNIT_CMP   = 2'd2;
  localparam logic [UNIT_W-1:0] UNIT_SHIFT = 2'd3;

`ifdef ALU_COLLECT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int DEFAULT_OUT_WIDTH = 16;

  function automatic int entry_width(input int out_w);
    return out_w + UNIT_W + PAR_W;
  endfunction

  localparam int RES_ENTRY_W = entry_width(DEFAULT_OUT_WIDTH);

  typedef enum logic [3:0] {
    ALU_FUN_ADD    = 4'b0000,
    ALU_FUN_SUB    = 4'b0001,
    ALU_FUN_MUL    = 4'b0010,
    ALU_FUN_DIV    = 4'b0011,
    ALU_FUN_AND    = 4'b0100,
    ALU_FUN_OR     = 4'b0101,
    ALU_FUN_NAND   = 4'b0110,
    ALU_FUN_NOR    = 4'b0111,
    ALU_FUN_XOR    = 4'b1000,
    ALU_FUN_XNOR   = 4'b1001,
    ALU_FUN_CMP_EQ = 4'b1010,
    ALU_FUN_CMP_GT = 4'b1011,
    ALU_FUN_CMP_LT = 4'b1100,
    ALU_FUN_SHR    = 4'b1101,
    ALU_FUN_SHL    = 4'b1110,
    ALU_FUN_NOP    = 4'b1111
  } alu_fun_t;

  // Fixed priority: arith > logic > cmp > shift (bit 0 is arith).
  function automatic logic [UNIT_W-1:0] prio_unit(input logic [NUM_UNITS-1:0] flags);
    if (flags[0])      return UNIT_ARITH;
    else if (flags[1]) return UNIT_LOGIC;
    else if (flags[2]) return UNIT_CMP;
    else               return UNIT_SHIFT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_collector_if
// Description : Function-unit result bus and consumer handshake of the collector.
//               Res_Parity exists only when ALU_COLLECT_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_collector_if #(
  parameter int OUT_WIDTH = 16
);
  logic [OUT_WIDTH-1:0] Arith_OUT;
  logic                 Arith_Flag;
  logic [OUT_WIDTH-1:0] Logic_OUT;
  logic                 Logic_Flag;
  logic [OUT_WIDTH-1:0] CMP_OUT;
  logic                 CMP_Flag;
  logic [OUT_WIDTH-1:0] Shift_OUT;
  logic                 Shift_Flag;
  logic                 Res_Ready;
  logic                 Clr_Err;
  logic                 Res_Valid;
  logic [OUT_WIDTH-1:0] Res_Data;
  logic [1:0]           Res_Unit;
  logic                 Overflow;
  logic                 Multi_Err;
`ifdef ALU_COLLECT_PARITY_EN
  logic                 Res_Parity;
`endif

  modport master (
`ifdef ALU_COLLECT_PARITY_EN
    input  Res_Parity,
`endif
    output Arith_OUT, Arith_Flag, Logic_OUT, Logic_Flag,
    output CMP_OUT, CMP_Flag, Shift_OUT, Shift_Flag,
    output Res_Ready, Clr_Err,
    input  Res_Valid, Res_Data, Res_Unit, Overflow, Multi_Err
  );

  modport slave (
`ifdef ALU_COLLECT_PARITY_EN
    output Res_Parity,
`endif
    input  Arith_OUT, Arith_Flag, Logic_OUT, Logic_Flag,
    input  CMP_OUT, CMP_Flag, Shift_OUT, Shift_Flag,
    input  Res_Ready, Clr_Err,
    output Res_Valid, Res_Data, Res_Unit, Overflow, Multi_Err
  );

endinterface
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Synchronous FIFO, registered storage and read mux, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  wire logic                     CLK,
  input  wire logic                     RST,
  input  wire logic                     i_push,
  input  wire logic [WIDTH-1:0]         i_wr_data,
  input  wire logic                     i_pop,
  output logic      [WIDTH-1:0]         o_rd_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_depth_cnt = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_count == c_depth_cnt);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_collector
// Description : Captures flagged ALU unit results, tags them by source and queues
//               them for a valid/ready consumer. Optional: ALU_COLLECT_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input wire logic               CLK,
  input wire logic               RST,
  alu_result_collector_if.slave  bus
);
  localparam int ENTRY_W = entry_width(OUT_WIDTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [NUM_UNITS-1:0] r_flag_q;
  logic                 r_overflow;
  logic                 r_multi_err;

  logic                 w_req;
  logic                 w_multi;
  logic [UNIT_W-1:0]    w_sel_unit;
  logic [OUT_WIDTH-1:0] w_sel_data;
  logic [ENTRY_W-1:0]   w_wr_entry;
  logic [ENTRY_W-1:0]   w_rd_entry;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  // Flags lead their data by one cycle; registering them aligns the two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_flag_q <= '0;
    else      r_flag_q <= {bus.Shift_Flag, bus.CMP_Flag, bus.Logic_Flag, bus.Arith_Flag};
  end

  assign w_req      = |r_flag_q;
  assign w_multi    = (r_flag_q & (r_flag_q - 1'b1)) != '0;
  assign w_sel_unit = prio_unit(r_flag_q);

  always_comb begin
    w_sel_data = bus.Arith_OUT;
    case (w_sel_unit)
      UNIT_LOGIC: w_sel_data = bus.Logic_OUT;
      UNIT_CMP:   w_sel_data = bus.CMP_OUT;
      UNIT_SHIFT: w_sel_data = bus.Shift_OUT;
      default:    w_sel_data = bus.Arith_OUT;
    endcase
  end

`ifdef ALU_COLLECT_PARITY_EN
  assign w_wr_entry = {^w_sel_data, w_sel_unit, w_sel_data};
`else
  assign w_wr_entry = {w_sel_unit, w_sel_data};
`endif

  assign w_pop  = bus.Res_Ready && !w_empty;
  assign w_push = w_req && (!w_full || w_pop);
  assign w_drop = w_req && w_full && !w_pop;

  alu_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .i_push    (w_push),
    .i_wr_data (w_wr_entry),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_entry),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Sticky errors: a set in the same cycle as Clr_Err wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_overflow  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      if (w_drop)           r_overflow <= 1'b1;
      else if (bus.Clr_Err) r_overflow <= 1'b0;
      if (w_multi)          r_multi_err <= 1'b1;
      else if (bus.Clr_Err) r_multi_err <= 1'b0;
    end
  end

  assign bus.Res_Valid = (w_count != '0);
  assign bus.Res_Data  = w_rd_entry[OUT_WIDTH-1:0];
  assign bus.Res_Unit  = w_rd_entry[OUT_WIDTH +: UNIT_W];
  assign bus.Overflow  = r_overflow;
  assign bus.Multi_Err = r_multi_err;
`ifdef ALU_COLLECT_PARITY_EN
  assign bus.Res_Parity = w_rd_entry[OUT_WIDTH+UNIT_W];
`endif

endmodule
`default_nettype wire
